// File: rtl/ifu_fq_pkg.sv
// Shared types for the fetch unit: the fetch-queue entry and the request tag.
// Struct field widths are fixed here, so the top-level width parameters must keep their defaults.
package ifu_fq_pkg;

    localparam int XLEN_D      = 32;
    localparam int INSTR_LEN_D = 32;
    localparam int INSTR_BYTES = 4;

    typedef struct packed {
        logic [INSTR_LEN_D-1:0] instr;
        logic [XLEN_D-1:0]      pc;
        logic                   pred_taken;
    } fq_entry_t;

    typedef struct packed {
        logic              pred_taken;
        logic [XLEN_D-1:0] pc;
    } fetch_tag_t;

endpackage

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush; push while full is accepted only together with a pop.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == CW'(DEPTH));
    assign o_count   = r_cnt;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Head reads zero while empty so downstream sees clean fields.
    assign o_data    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + PW'(1);
            if (w_do_pop)  r_rd <= r_rd + PW'(1);
            r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/ifu_fq.sv
// Instruction fetch unit: predictor-steered PC, credit-limited outstanding requests,
// a registered fetch queue, and drop counting of stale responses after a redirect.
module ifu_fq import ifu_fq_pkg::*; #(
    parameter int XLEN      = XLEN_D,
    parameter int INSTR_LEN = INSTR_LEN_D,
    parameter int ADDR_W    = 16,
    parameter int FQ_DEPTH  = 4,
    parameter int MAX_OUT   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      reset_vector,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic [XLEN:0]        mem_req_tag,
    input  logic                 mem_rsp_valid,
    input  logic [INSTR_LEN-1:0] mem_rsp_data,
    input  logic [XLEN:0]        mem_rsp_tag,
    output logic [XLEN-1:0]      pred_pc,
    input  logic                 pred_taken,
    input  logic [XLEN-1:0]      pred_target,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [INSTR_LEN-1:0] instr,
    output logic [XLEN-1:0]      instr_pc,
    output logic                 instr_pred_taken
);
    localparam int OW = $clog2(MAX_OUT+1);
    localparam int CW = $clog2(FQ_DEPTH+1);
    localparam int SW = $clog2(MAX_OUT+FQ_DEPTH+1);

    logic [XLEN-1:0] r_pc;
    logic [OW-1:0]   r_out;
    logic [OW-1:0]   r_drop;
    logic [CW-1:0]   w_fq_count;
    logic [SW-1:0]   w_credit;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_fq_full;
    logic            w_fq_empty;
    fetch_tag_t      w_rsp_tag;
    fq_entry_t       w_push_entry;
    fq_entry_t       w_head;

    // Reserving an FQ slot per outstanding request means responses never need backpressure.
    assign w_credit      = SW'(r_out) + SW'(w_fq_count);
    assign mem_req_valid = !rst && !redirect_valid && (r_out < OW'(MAX_OUT))
                           && (w_credit < SW'(FQ_DEPTH));
    assign w_fire        = mem_req_valid && mem_req_ready;
    assign mem_req_addr  = r_pc[ADDR_W-1:0];
    assign mem_req_tag   = {pred_taken, r_pc};
    assign pred_pc       = r_pc;

    assign w_rsp_tag    = mem_rsp_tag;
    assign w_push       = mem_rsp_valid && !redirect_valid && (r_drop == '0);
    assign w_pop        = instr_valid && instr_ready && !redirect_valid;
    assign w_push_entry = '{instr: mem_rsp_data, pc: w_rsp_tag.pc, pred_taken: w_rsp_tag.pred_taken};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= reset_vector;
            r_out  <= '0;
            r_drop <= '0;
        end else begin
            if (redirect_valid)
                r_pc <= redirect_pc;
            else if (w_fire)
                r_pc <= pred_taken ? pred_target : r_pc + XLEN'(INSTR_BYTES);
            r_out <= r_out + OW'(w_fire) - OW'(mem_rsp_valid);
            // Everything still in flight after a redirect is stale, including already-doomed requests.
            if (redirect_valid)
                r_drop <= r_out - OW'(mem_rsp_valid);
            else if (mem_rsp_valid && (r_drop != '0))
                r_drop <= r_drop - OW'(1);
        end
    end

    ifu_fifo #(
        .WIDTH ($bits(fq_entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_fq_count),
        .o_full  (w_fq_full),
        .o_empty (w_fq_empty)
    );

    assign instr_valid      = !w_fq_empty;
    assign instr            = w_head.instr;
    assign instr_pc         = w_head.pc;
    assign instr_pred_taken = w_head.pred_taken;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(w_push && w_fq_full && !w_pop));
    a_rsp_has_req: assert property (@(posedge clk) disable iff (rst)
        mem_rsp_valid |-> (r_out != '0));
    a_drop_le_out: assert property (@(posedge clk) disable iff (rst)
        r_drop <= r_out);

endmodule

// File: tb/tb_ifu_fq.sv
// Directed bench for ifu_fq: in-order memory model with variable latency and a
// request-time scoreboard that is cleared on redirect.
module tb_ifu_fq;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] reset_vector;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_req_addr;
    logic [32:0] mem_req_tag;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [32:0] mem_rsp_tag;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_pred_taken;

    always #5 clk = ~clk;

    ifu_fq #(
        .XLEN(32), .INSTR_LEN(32), .ADDR_W(16), .FQ_DEPTH(4), .MAX_OUT(2)
    ) dut (
        .clk(clk), .rst(rst), .reset_vector(reset_vector),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pred_taken(instr_pred_taken)
    );

    typedef struct { logic [32:0] tag; int due; bit drop; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; logic pred; } exp_t;

    mreq_t       mq[$];
    exp_t        expq[$];
    logic [31:0] pop_log[$];
    int          ntests = 0, nfail = 0, cyc = 0, lat = 1, model_fq = 0, n_pop = 0, max_out = 0, n0;
    logic [31:0] model_pc = '0;
    logic [15:0] prev_addr = '0, addr_after_1008 = '0;
    logic        pop_pred_1008 = 1'b0;
    bit          pred_mode = 0, arm_redir = 0, redir_fired = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0F0F_5A5A;
    endfunction

    task automatic chk(input string name, input logic [95:0] obs, input logic [95:0] req);
        ntests++;
        assert (obs === req) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", name, obs, req);
        end
    endtask

    // Everything seen here is what the next clock edge will commit.
    task automatic observe();
        bit    pop;
        exp_t  e;
        mreq_t m;
        if (rst) begin
            chk("rst_req_valid", mem_req_valid, 1'b0);
            mq.delete(); expq.delete(); model_fq = 0; model_pc = reset_vector;
            return;
        end
        chk("req_valid", mem_req_valid,
            (mq.size() < 2) && (mq.size() + model_fq < 4) && !redirect_valid);
        chk("instr_valid", instr_valid, model_fq != 0);
        if (model_fq == 0) chk("empty_head", {instr_pred_taken, instr_pc, instr}, '0);
        if (mq.size() > max_out) max_out = mq.size();
        pop = instr_valid && instr_ready && !redirect_valid;
        if (pop) begin
            n_pop++;
            pop_log.push_back(instr_pc);
            if (instr_pc == 32'h1008) pop_pred_1008 = instr_pred_taken;
            ntests++;
            assert (expq.size() != 0) else begin
                nfail++;
                $error("FAIL pop_unexpected: observed pc %0h required no delivery", instr_pc);
            end
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("pop_pc", instr_pc, e.pc);
                chk("pop_instr", instr, e.data);
                chk("pop_pred", instr_pred_taken, e.pred);
            end
        end
        if (mem_rsp_valid) begin
            m = mq.pop_front();
            if (!m.drop && !redirect_valid) model_fq++;
        end
        if (pop && model_fq > 0) model_fq--;
        if (redirect_valid) begin
            foreach (mq[i]) mq[i].drop = 1;
            expq.delete();
            model_fq = 0;
            model_pc = redirect_pc;
        end else if (mem_req_valid && mem_req_ready) begin
            chk("req_addr", mem_req_addr, model_pc[15:0]);
            chk("req_tag", mem_req_tag, {pred_taken, model_pc});
            if (prev_addr == 16'h1008) addr_after_1008 = mem_req_addr;
            prev_addr = mem_req_addr;
            mq.push_back('{tag: mem_req_tag, due: cyc + lat, drop: 0});
            expq.push_back('{pc: model_pc, data: memf(model_pc), pred: pred_taken});
            model_pc = pred_taken ? pred_target : model_pc + 32'd4;
        end
    endtask

    task automatic tick();
        logic [32:0] t;
        mem_rsp_valid = 1'b0;
        mem_rsp_tag   = '0;
        mem_rsp_data  = '0;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            t = mq[0].tag;
            mem_rsp_valid = 1'b1;
            mem_rsp_tag   = t;
            mem_rsp_data  = memf(t[31:0]);
        end
        pred_taken = pred_mode && (pred_pc == 32'h1008);
        if (arm_redir && mem_rsp_valid && instr_valid && instr_ready) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h3800;
            arm_redir      = 0;
            redir_fired    = 1;
        end
        #1;
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst = 1'b1; reset_vector = 32'h1000; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
        pred_taken = 1'b0; pred_target = 32'h2000;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        @(posedge clk); #1;
        tick();
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_instr_pred", instr_pred_taken, 1'b0);

        // Streaming with single-cycle memory
        rst = 1'b0; instr_ready = 1'b1; pop_log.delete();
        #1;
        chk("first_req_valid", mem_req_valid, 1'b1);
        chk("first_req_addr", mem_req_addr, 16'h1000);
        chk("first_req_tag", mem_req_tag, {1'b0, 32'h1000});
        tick();
        chk("no_early_valid", instr_valid, 1'b0);
        repeat (3) tick();
        n0 = n_pop;
        repeat (8) tick();
        chk("stream_rate", n_pop - n0, 8);
        chk("stream_pc0", pop_log[0], 32'h1000);
        chk("stream_pc1", pop_log[1], 32'h1004);
        chk("stream_pc2", pop_log[2], 32'h1008);
        chk("max_outstanding_ok", max_out <= 2, 1'b1);

        // Backpressure fills the queue, then drains with issue blocked
        instr_ready = 1'b0;
        repeat (10) tick();
        chk("bp_req_blocked", mem_req_valid, 1'b0);
        chk("bp_head_valid", instr_valid, 1'b1);
        mem_req_ready = 1'b0; instr_ready = 1'b1; n0 = n_pop;
        repeat (8) tick();
        chk("bp_drain_count", n_pop - n0, 4);

        // Taken prediction at 0x1008
        rst = 1'b1; reset_vector = 32'h1000;
        tick();
        rst = 1'b0; mem_req_ready = 1'b1; pred_mode = 1;
        repeat (10) tick();
        pred_mode = 0;
        chk("pred_next_addr", addr_after_1008, 16'h2000);
        chk("pred_bit_1008", pop_pred_1008, 1'b1);

        // Redirect with two requests in flight, latency 3
        lat = 3;
        repeat (3) tick();
        for (int i = 0; i < 20 && mq.size() != 2; i++) tick();
        chk("redir1_outstanding", mq.size(), 2);
        redirect_valid = 1'b1; redirect_pc = 32'h3000;
        tick();
        redirect_valid = 1'b0;
        chk("redir1_flush", instr_valid, 1'b0);
        pop_log.delete();
        for (int i = 0; i < 30 && pop_log.size() == 0; i++) tick();
        chk("redir1_first_pc", (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_DEAD, 32'h3000);

        // Redirect coinciding with response and pop, then back-to-back redirect
        lat = 2;
        repeat (6) tick();
        redir_fired = 0; arm_redir = 1;
        for (int i = 0; i < 20 && !redir_fired; i++) tick();
        arm_redir = 0;
        chk("redir2_coincident", redir_fired, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h4000; pop_log.delete();
        tick();
        redirect_valid = 1'b0;
        chk("redir2_flush", instr_valid, 1'b0);
        for (int i = 0; i < 30 && pop_log.size() == 0; i++) tick();
        chk("redir2_first_pc", (pop_log.size() != 0) ? pop_log[0] : 32'hDEAD_DEAD, 32'h4000);
        mem_req_ready = 1'b0;
        repeat (6) tick();
        chk("idle_outstanding", mq.size(), 0);
        chk("idle_req_valid", mem_req_valid, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/ifu_fq.md
Name: ifu_fq

Overview:
- Second-generation instruction fetch unit with a parametrised fetch queue (FQ) and multiple outstanding memory requests.
- Sits between the instruction memory and decode.
- Queries an external direction predictor at issue time and steers the next fetch to the predicted target.
- On an EXU redirect, flushes the FQ and silently discards in-flight responses. This replaces flush-on-load with drop counting and the stall input with a valid/ready handshake.

Parameters:
- XLEN, 32, PC / data-path width.
- INSTR_LEN, 32, instruction width (fixed 4-byte fetch).
- ADDR_W, 16, instruction memory address width; low ADDR_W bits of PC.
- FQ_DEPTH, 4, fetch queue entries (power of 2, >=2).
- MAX_OUT, 2, maximum outstanding memory requests (1..FQ_DEPTH).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; one clock; reset is synchronous and active-high.
- reset_vector, in, XLEN, PC loaded while rst.
- mem_req_valid, out, 1, fetch request valid.
- mem_req_ready, in, 1, memory accepts request.
- mem_req_addr, out, ADDR_W, pc[ADDR_W-1:0].
- mem_req_tag, out, XLEN+1, {pred_taken, pc}.
- mem_rsp_valid, in, 1, response valid; responses return strictly in request order and are always accepted.
- mem_rsp_data, in, INSTR_LEN, instruction.
- mem_rsp_tag, in, XLEN+1, echoed request tag.
- pred_pc, out, XLEN, current fetch PC to predictor (combinational).
- pred_taken, in, 1, same-cycle direction prediction.
- pred_target, in, XLEN, same-cycle predicted target.
- redirect_valid, in, 1, EXU redirect (mispredict / jump).
- redirect_pc, in, XLEN, redirect target.
- instr_valid, out, 1, FQ head valid.
- instr_ready, in, 1, decode accepts head.
- instr, out, INSTR_LEN, head instruction.
- instr_pc, out, XLEN, head PC.
- instr_pred_taken, out, 1, head prediction bit.

Behaviour:
- Reset (rst=1 at clk edge):
  - pc=reset_vector; FQ empty; outstanding=0; drop_cnt=0.
  - mem_req_valid=0, instr_valid=0.
  - instr, instr_pc and instr_pred_taken read 0 when empty.
  - Reset mid-transfer: responses already in flight at reset are the integrator's responsibility; memory is reset together with this block.
- Issue condition:
  - mem_req_valid = !rst & !redirect_valid & (outstanding < MAX_OUT) & (outstanding + fq_count < FQ_DEPTH).
  - This credit rule guarantees every response has an FQ slot, so there is no response backpressure.
- On a request handshake (valid & ready):
  - Tag carries pred_taken.
  - pc <= pred_taken ? pred_target : pc+4 (XLEN modulo wrap).
  - outstanding increments.
- No handshake: pc holds.
- Response handling:
  - outstanding decrements on every mem_rsp_valid, including dropped responses.
  - If drop_cnt>0: response discarded, drop_cnt--.
  - Otherwise: pushed to FQ tail as {data, tag.pc, tag.pred_taken}.
- Response-to-instr_valid latency: 1 cycle; the FQ is registered, with no bypass.
- Dequeue: instr_valid & instr_ready pops the head. Push and pop in the same cycle are legal at any occupancy, including full.
- Redirect (highest priority):
  - pc <= redirect_pc.
  - FQ flushed; instr_valid=0 next cycle, and any pop that cycle is ignored.
  - No request issued that cycle.
  - drop_cnt <= outstanding minus this cycle's response, if any. This counts every still-outstanding request, including ones already scheduled for dropping.
  - A response arriving in the redirect cycle is dropped.
- Back-to-back redirects: each recomputes drop_cnt from outstanding; the last redirect_pc wins.
- Counter widths:
  - outstanding needs clog2(MAX_OUT+1) bits; drop_cnt uses the same width.
  - fq_count needs clog2(FQ_DEPTH+1) bits.
  - FQ pointers are clog2(FQ_DEPTH) bits, wrapping naturally.
- Assertions:
  - no push when full;
  - no mem_rsp_valid when outstanding==0;
  - drop_cnt <= outstanding.

Decomposition:
- Shared package: fq_entry_t struct {instr, pc, pred_taken}; fetch_tag_t {pred_taken, pc}; INSTR_BYTES=4.
- One sub-module, ifu_fifo: generic synchronous FIFO parametrised by width/depth, with push/pop/flush/count/full/empty.
- Issue logic, PC register and drop/outstanding counters live in ifu_fq.

Test Plan:
- Reset: rst=1 with reset_vector=0x1000 -> after release, first mem_req_addr=0x1000 with tag pc 0x1000; instr_valid=0 until the first response.
- Streaming, 1-cycle memory, instr_ready=1, pred_taken=0 -> PCs 0x1000, 0x1004, 0x1008 appear on instr_pc, one per cycle after fill, with outstanding never exceeding MAX_OUT.
- Backpressure: instr_ready=0 -> exactly FQ_DEPTH instructions buffered, then mem_req_valid stays 0. Releasing instr_ready drains them in order with no loss or duplication.
- Prediction: pred_taken=1, pred_target=0x2000 at pc 0x1008 -> next request addr 0x2000; instr_pred_taken=1 on the 0x1008 entry.
- Redirect with 2 outstanding (memory latency 3): redirect_pc=0x3000 -> FQ empties next cycle and both stale responses are dropped. The first delivered instr_pc is 0x3000.
- Redirect on the same cycle as a response and a pop, then a second redirect 1 cycle later to 0x4000 -> no stale instruction is delivered, the first instr_pc is 0x4000, and outstanding returns to 0.
